// File: rtl/ldm_stm_sequencer.sv
// rtl/ldm_stm_sequencer.sv - load/store-multiple register-list sequencer
module ldm_stm_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic              start,
  input  logic              is_load,
  input  logic              up,
  input  logic              pre,
  input  logic [15:0]       reg_list,
  input  logic [ADDR_W-1:0] base,
  input  logic              mem_moc,
  output logic [19:0]       RSLCT,
  output logic              rf_load,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] wb_addr
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

  state_t            state, state_nxt;
  logic [15:0]       list_q;
  logic [15:0]       list_clr;
  logic              load_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        n;
  logic [3:0]        k;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;

  // Register count and block span; memory always ascends, so decrement modes start below base.
  always_comb begin
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0, reg_list[i]};
    span = ADDR_W'(n) * STEP;
    if (up) begin
      start_addr = pre ? base + STEP : base;
      end_addr   = base + span;
    end else begin
      start_addr = pre ? base - span : base - span + STEP;
      end_addr   = base - span;
    end
  end

  // Lowest-numbered remaining register and the list with it removed.
  always_comb begin
    k = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) k = 4'(i);
    end
    list_clr = list_q & ~(16'b1 << k);
  end

  // State register.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    RSLCT     = '0;
    rf_load   = 1'b0;
    mem_req   = 1'b0;
    mem_rw    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (n == 5'd0) ? S_DONE : S_XFER;
      end
      S_XFER: begin
        mem_req = 1'b1;
        mem_rw  = load_q;
        rf_load = load_q & mem_moc;
        RSLCT   = load_q ? (20'(k) << 12) : (20'(k) << 4);
        if (mem_moc && list_clr == 16'h0) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem_addr = addr_q;

  // Transfer context: latched on start, advanced once per completed memory word.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      list_q  <= '0;
      load_q  <= 1'b0;
      addr_q  <= '0;
      wb_addr <= '0;
    end else if (state == S_IDLE && start) begin
      list_q  <= reg_list;
      load_q  <= is_load;
      addr_q  <= start_addr;
      wb_addr <= end_addr;
    end else if (state == S_XFER && mem_moc) begin
      list_q  <= list_clr;
      addr_q  <= addr_q + STEP;
    end
  end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
- Control-side driver of the register file's select/load interface for block transfers (load/store multiple).
- Walks a 16-bit register list lowest-numbered first and generates one memory word transfer per set bit.
- Per transfer it drives the 20-bit register-select bus (RSLCT), the write strobe and the memory address/request handshake.
- Sits between the control unit, the register file and the memory interface; returns the final base value for optional base writeback.

Parameters:
ADDR_W, 32, width of base and memory addresses
WORD_BYTES, 4, address step per transferred register

Ports:
Clk  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
start  in  1  begin block transfer; sampled in IDLE only
is_load  in  1  1 = LDM (memory to registers), 0 = STM
up  in  1  1 = increment addressing, 0 = decrement
pre  in  1  1 = pre-index (IB/DB), 0 = post-index (IA/DA)
reg_list  in  16  register mask, bit i = Ri
base  in  ADDR_W  base address
mem_moc  in  1  memory operation complete, valid while mem_req=1
RSLCT  out  20  register selects: [19:16] Rn, [15:12] Rd, [11:8] Rs, [7:4] Rm, [3:0] alt Rn
rf_load  out  1  register file write strobe
mem_req  out  1  memory function request
mem_rw  out  1  1 = read (LDM), 0 = write (STM)
mem_addr  out  ADDR_W  current word address
busy  out  1  high outside IDLE
done  out  1  one-cycle completion pulse
wb_addr  out  ADDR_W  final base for writeback; valid when done=1, held until next start

Behaviour:
- Async RESET high: state IDLE; all outputs 0, including RSLCT, wb_addr and mem_addr; latched list cleared; no rf_load is issued during or after reset.
- States: IDLE, XFER, DONE.
- IDLE:
  - busy=0.
  - On start=1: latch is_load, reg_list, base; compute n = popcount(reg_list).
  - Set start address by mode: IA = base; IB = base+4; DA = base-4n+4; DB = base-4n (4 = WORD_BYTES).
  - Set wb_addr: up gives base+4n; down gives base-4n.
  - If n=0: go to DONE with no memory cycle and wb_addr=base. Otherwise go to XFER.
- XFER:
  - mem_req=1, mem_rw=is_load, mem_addr = current address.
  - k = lowest set bit of the remaining list.
  - STM: RSLCT[7:4]=k, so Rm presents the store data; all other fields 0.
  - LDM: RSLCT[15:12]=k; all other fields 0.
  - Outputs are held stable while mem_moc=0; there is no timeout.
  - In a cycle with mem_moc=1:
    - LDM: rf_load=1 for exactly that cycle (data captured at that edge).
    - Clear bit k and advance address by +4.
    - If the remaining list is 0, go to DONE; else stay in XFER with the next k.
  - rf_load is never asserted for STM or outside a mem_moc=1 cycle.
- Throughput: with mem_moc tied high, one register per cycle. start at edge t gives first mem_req at t+1; done follows the cycle after the last accepted transfer.
- Addresses always ascend in memory regardless of up: lowest register goes to the lowest address. Arithmetic is modulo 2^ADDR_W (wraps silently). base[1:0] is used as given; no alignment check.
- DONE: done=1, busy=1, mem_req=0, RSLCT=0 for one cycle; then IDLE.
- start while busy is ignored and not queued. mem_moc is ignored when mem_req=0.
- Reset mid-transfer aborts immediately. Partial register writes already done remain. No done pulse.

Test Plan:
- STM IA, list 0x000B, base 0x1000, moc=1:
  - Addresses 0x1000/0x1004/0x1008.
  - RSLCT[7:4] = 0, 1, 3.
  - mem_rw=0, rf_load never high.
  - done at cycle 4, wb_addr 0x100C.
- LDM DB, list 0x8001, base 0x2000:
  - Addresses 0x1FF8 (RSLCT[15:12]=0), then 0x1FFC (=15).
  - Two single-cycle rf_load pulses.
  - wb_addr 0x1FF8.
- LDM IA, list 0x0004, base 0x40, moc low for 3 cycles then high:
  - mem_req, mem_addr 0x40 and RSLCT[15:12]=2 held for 4 cycles.
  - rf_load only in the 4th cycle.
- Empty list, base 0x500:
  - No mem_req.
  - done one cycle after start, wb_addr 0x500.
- Wrap, STM IA, list 0x0003, base 0xFFFFFFFC:
  - Addresses 0xFFFFFFFC then 0x00000000.
  - wb_addr 0x00000004.
- start pulsed mid-transfer:
  - Ignored.
- RESET asserted during the 2nd XFER cycle of LDM list 0x00FF:
  - Outputs immediately 0; no further rf_load; no done.
  - Next start proceeds normally.
